edge_bbox_scanner: RTL
======================

// Module: edge_bbox_scanner
// PURPOSE
//  Downstream of the SD-to-BRAM edge loader. Once the edge-map BRAM is fully loaded, raster-scans it one pixel per clock.
//  Reports the bounding box and edge-pixel count of all set pixels to the wing-tracking logic.
//  Pipelined against a fixed BRAM read latency.
// PARAMETERS
//  WIDTH         640     image width in pixels
//  HEIGHT        480     image height in pixels
//  READ_LATENCY  2       BRAM addr-to-dout latency in clocks (1..4)
// PORTS
//  clk         in   1   system clock, all logic on posedge
//  reset_n     in   1   asynchronous, active-low reset
//  start       in   1   begin scan; driven by loader's done (level or pulse accepted)
//  bram_addr   out  19  pixel address, y*WIDTH+x
//  bram_en     out  1   BRAM read enable (port B, read-only)
//  bram_dout   in   3   BRAM data; bit0 = edge pixel, bits[2:1] ignored
//  busy        out  1   high in SCAN and DRAIN
//  done        out  1   high from end of scan until next accepted start
//  box_valid   out  1   at least one edge pixel seen in the last scan
//  x_min/x_max out  10  bounding box columns
//  y_min/y_max out  9   bounding box rows
//  edge_count  out  19  number of edge pixels
//  sum_x       out  28  sum of x over edge pixels (CENTROID_EN only)
//  sum_y       out  28  sum of y over edge pixels (CENTROID_EN only)
// BEHAVIOUR
//  Reset values: bram_addr=0, bram_en=0, busy=0, done=0, box_valid=0.
//   x_min=WIDTH-1, x_max=0, y_min=HEIGHT-1, y_max=0, edge_count=0, sums=0; state=IDLE.
//  FSM states: IDLE, SCAN, DRAIN, DONE.
//  IDLE/DONE -> SCAN on start=1: results reinit to reset values, done<=0, busy<=1, bram_addr<=0, bram_en<=1.
//  SCAN: one address per clock. x counter wraps to 0 at WIDTH-1 and increments y.
//   Last address is WIDTH*HEIGHT-1; the next clock goes to DRAIN and sets bram_en<=0.
//  Pipeline: (x,y,valid) delayed READ_LATENCY stages alongside the address.
//   bram_dout[0] is sampled only when the delayed valid is high.
//  Update on a sampled edge pixel:
//   edge_count+1; x_min=min, x_max=max, y_min=min, y_max=max; box_valid<=1.
//  DRAIN: lasts exactly READ_LATENCY clocks, flushes the pipeline, then DONE with busy<=0, done<=1.
//  Timing: start sampled in cycle 0 -> addr k presented in cycle 1+k.
//   done first high in cycle WIDTH*HEIGHT+READ_LATENCY+1.
//  DONE holds all results stable. Another start restarts the scan; a level start therefore rescans continuously.
//  start while busy is ignored; the scan is not restarted or perturbed.
//  No edges found: box_valid=0, box/count keep reset values.
//  reset_n low at any time, including mid-scan: all outputs immediately take reset values; any partial result is discarded.
//  Widths: edge_count max 307200 fits 19b. Sums max ~1.97e8 fit 28b; no saturation needed.
// CONFIGURATION
//  CENTROID_EN defined: sum_x/sum_y accumulate the delayed x/y of each edge pixel.
//   They are cleared on start and reset; the consumer divides by edge_count.
//  CENTROID_EN undefined: no accumulators; sum_x/sum_y tied to 0.
// TESTING
//  (bench uses WIDTH=8, HEIGHT=4, READ_LATENCY=2 unless noted)
//  T1 all-zero BRAM, start pulse -> done rises in cycle 35; box_valid=0, edge_count=0, x_min=7, y_min=3.
//  T2 single edge at addr 29 (x=5,y=3) -> x_min=x_max=5, y_min=y_max=3, edge_count=1, box_valid=1.
//  T3 edges at addr 0 and 31 -> box (0,0)-(7,3), edge_count=2; CENTROID_EN: sum_x=7, sum_y=3.
//  T4 start re-pulsed mid-scan -> ignored, done still in cycle 35.
//     Start again after done with an empty BRAM -> results clear, box_valid=0.
//  T5 reset_n low at cycle 10 of a scan -> same cycle busy=0, bram_en=0, edge_count=0; state IDLE after release.
//  T6 default params, READ_LATENCY=1, edge at addr 307199 -> done in cycle 307202; x_max=639, y_max=479.

Source files
------------

// File: rtl/edge_bbox_scanner.sv
// Raster-scans a loaded edge-map BRAM and reports bounding box, edge count and
// (when `CENTROID_EN is defined) coordinate sums of all set pixels.
module edge_bbox_scanner #(
  parameter int WIDTH        = 640,
  parameter int HEIGHT       = 480,
  parameter int READ_LATENCY = 2
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  output logic [18:0] bram_addr,
  output logic        bram_en,
  input  logic [2:0]  bram_dout,
  output logic        busy,
  output logic        done,
  output logic        box_valid,
  output logic [9:0]  x_min,
  output logic [9:0]  x_max,
  output logic [8:0]  y_min,
  output logic [8:0]  y_max,
  output logic [18:0] edge_count,
  output logic [27:0] sum_x,
  output logic [27:0] sum_y
);

  localparam logic [9:0]  X_LAST = 10'(WIDTH - 1);
  localparam logic [8:0]  Y_LAST = 9'(HEIGHT - 1);
  localparam logic [18:0] A_LAST = 19'(WIDTH * HEIGHT - 1);
  localparam logic [1:0]  D_LAST = 2'(READ_LATENCY - 1);

  typedef enum logic [1:0] {IDLE, SCAN, DRAIN, DONE} state_t;

  state_t      state_q;
  logic [9:0]  x_q, x_d;
  logic [8:0]  y_q, y_d;
  logic [1:0]  drain_q;

  logic        vld_q [0:READ_LATENCY-1];
  logic [9:0]  px_q  [0:READ_LATENCY-1];
  logic [8:0]  py_q  [0:READ_LATENCY-1];

  logic        accept;
  logic        hit;
  logic [9:0]  hx;
  logic [8:0]  hy;
  logic        unused_dout;

  assign accept      = ((state_q == IDLE) || (state_q == DONE)) && start;
  assign hit         = vld_q[READ_LATENCY-1] & bram_dout[0];
  assign hx          = px_q[READ_LATENCY-1];
  assign hy          = py_q[READ_LATENCY-1];
  assign unused_dout = ^bram_dout[2:1];

  always_comb begin
    x_d = x_q + 10'd1;
    y_d = y_q;
    if (x_q == X_LAST) begin
      x_d = '0;
      y_d = y_q + 9'd1;
    end
  end

  // Scan control: address generation, drain timer and status flags
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      bram_addr <= '0;
      bram_en   <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      x_q       <= '0;
      y_q       <= '0;
      drain_q   <= '0;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          if (start) begin
            state_q   <= SCAN;
            done      <= 1'b0;
            busy      <= 1'b1;
            bram_addr <= '0;
            bram_en   <= 1'b1;
            x_q       <= '0;
            y_q       <= '0;
          end
        end
        SCAN: begin
          if (bram_addr == A_LAST) begin
            state_q <= DRAIN;
            bram_en <= 1'b0;
            drain_q <= '0;
          end else begin
            bram_addr <= bram_addr + 19'd1;
            x_q       <= x_d;
            y_q       <= y_d;
          end
        end
        DRAIN: begin
          if (drain_q == D_LAST) begin
            state_q <= DONE;
            busy    <= 1'b0;
            done    <= 1'b1;
          end else begin
            drain_q <= drain_q + 2'd1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Coordinate pipeline matching the BRAM read latency; only valid is reset
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < READ_LATENCY; i++) vld_q[i] <= 1'b0;
    end else begin
      vld_q[0] <= bram_en;
      for (int i = 1; i < READ_LATENCY; i++) vld_q[i] <= vld_q[i-1];
    end
  end

  always_ff @(posedge clk) begin
    px_q[0] <= x_q;
    py_q[0] <= y_q;
    for (int i = 1; i < READ_LATENCY; i++) begin
      px_q[i] <= px_q[i-1];
      py_q[i] <= py_q[i-1];
    end
  end

  // Result accumulation on each sampled edge pixel
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      box_valid  <= 1'b0;
      x_min      <= X_LAST;
      x_max      <= '0;
      y_min      <= Y_LAST;
      y_max      <= '0;
      edge_count <= '0;
    end else if (accept) begin
      box_valid  <= 1'b0;
      x_min      <= X_LAST;
      x_max      <= '0;
      y_min      <= Y_LAST;
      y_max      <= '0;
      edge_count <= '0;
    end else if (hit) begin
      box_valid  <= 1'b1;
      edge_count <= edge_count + 19'd1;
      if (hx < x_min) x_min <= hx;
      if (hx > x_max) x_max <= hx;
      if (hy < y_min) y_min <= hy;
      if (hy > y_max) y_max <= hy;
    end
  end

`ifdef CENTROID_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sum_x <= '0;
      sum_y <= '0;
    end else if (accept) begin
      sum_x <= '0;
      sum_y <= '0;
    end else if (hit) begin
      sum_x <= sum_x + 28'(hx);
      sum_y <= sum_y + 28'(hy);
    end
  end
`else
  assign sum_x = '0;
  assign sum_y = '0;
`endif

endmodule
